// File: rtl/wgt_buf_loader_if.sv
// Weight stream input and weight-buffer write port of the loader.
// slave is the loader's view; master is the DMA/buffer side.
interface wgt_buf_loader_if #(parameter int DATA_WID = 16);
  logic                s_valid;
  logic [DATA_WID-1:0] s_data;
  logic                s_ready;
  logic                buf_wr_en;
  logic [7:0]          buf_wr_addr;
  logic [DATA_WID-1:0] buf_wr_data;

  modport master (output s_valid, s_data,
                  input  s_ready, buf_wr_en, buf_wr_addr, buf_wr_data);
  modport slave  (input  s_valid, s_data,
                  output s_ready, buf_wr_en, buf_wr_addr, buf_wr_data);
endinterface

// File: rtl/wgt_buf_loader.sv
// Loads one kernel set from the weight stream into one half of the
// ping-pong weight buffer, alternating halves and honouring release pulses.
//
// state     | meaning
// IDLE      | waiting for load_start
// CHECK     | validate kernel_size / word total, pick base address
// WAIT_HALF | target half still held by img2col
// LOAD      | accepting stream words, one buffer write per handshake
// DONE      | mark half full, report it, flip write pointer
module wgt_buf_loader #(
  parameter int         DATA_WID   = 16,
  parameter logic [7:0] HALF_BASE1 = 8'h80
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic [6:0] chn_num,
  input  logic [3:0] kernel_size,
  input  logic [1:0] half_release,
  output logic [1:0] half_full,
  output logic       load_done,
  output logic       load_half,
  output logic       busy,
  output logic       err_cfg,
  wgt_buf_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, WAIT_HALF, LOAD, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  chn_r;
  logic [3:0]  ks_r;
  logic [6:0]  total_m1;
  logic [7:0]  base;
  logic [6:0]  cnt;
  logic        wr_ptr;
  logic [13:0] total;
  logic        ks_ok;
  logic        cfg_bad;
  logic        ld_hs;
  logic [1:0]  set_mask;

  // 14 bits holds the worst case 128 * 121 without wrapping
  always_comb begin
    total = (14'(chn_r) + 14'd1) * 14'(ks_r) * 14'(ks_r);
    case (ks_r)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11: ks_ok = 1'b1;
      default:                             ks_ok = 1'b0;
    endcase
    cfg_bad = !ks_ok || (total > 14'd128);
  end

  assign bus.s_ready = (state == LOAD);
  assign ld_hs       = (state == LOAD) && bus.s_valid;
  assign set_mask    = (state == DONE) ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_done = 1'b0;
    err_cfg   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:      if (load_start) state_nxt = CHECK;
      CHECK: begin
        if (cfg_bad) begin
          err_cfg   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_HALF;
        end
      end
      WAIT_HALF: if (!half_full[wr_ptr]) state_nxt = LOAD;
      LOAD:      if (bus.s_valid && (cnt == total_m1)) state_nxt = DONE;
      DONE: begin
        load_done = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chn_r           <= '0;
      ks_r            <= '0;
      total_m1        <= '0;
      base            <= '0;
      cnt             <= '0;
      wr_ptr          <= 1'b0;
      load_half       <= 1'b0;
      half_full       <= 2'b00;
      bus.buf_wr_en   <= 1'b0;
      bus.buf_wr_addr <= '0;
      bus.buf_wr_data <= {DATA_WID{1'b0}};
    end else begin
      if ((state == IDLE) && load_start) begin
        chn_r <= chn_num;
        ks_r  <= kernel_size;
      end
      if ((state == CHECK) && !cfg_bad) begin
        total_m1 <= 7'(total - 14'd1);
        base     <= wr_ptr ? HALF_BASE1 : 8'h00;
        cnt      <= '0;
      end
      bus.buf_wr_en <= ld_hs;
      if (ld_hs) begin
        bus.buf_wr_addr <= base + {1'b0, cnt};
        bus.buf_wr_data <= bus.s_data;
        cnt             <= cnt + 7'd1;
      end
      if (state == DONE) begin
        load_half <= wr_ptr;
        wr_ptr    <= ~wr_ptr;
      end
      // a DONE set beats a release of the same half in the same cycle
      half_full <= set_mask | (half_full & ~half_release);
    end
  end

endmodule

// File: tb/tb_wgt_buf_loader.sv
// Directed load sequence with random weight data, checked against a
// word-list / half-occupancy model of the loader.
module tb_wgt_buf_loader;
  localparam int DW = 16;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic [6:0] chn_num;
  logic [3:0] kernel_size;
  logic [1:0] half_release;
  logic [1:0] half_full;
  logic       load_done;
  logic       load_half;
  logic       busy;
  logic       err_cfg;

  wgt_buf_loader_if #(.DATA_WID(DW)) bus ();

  wgt_buf_loader #(.DATA_WID(DW), .HALF_BASE1(8'h80)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .chn_num      (chn_num),
    .kernel_size  (kernel_size),
    .half_release (half_release),
    .half_full    (half_full),
    .load_done    (load_done),
    .load_half    (load_half),
    .busy         (busy),
    .err_cfg      (err_cfg),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [1:0]    m_full;
  logic          m_ptr;
  logic [DW-1:0] exp_words[$];
  logic [7:0]    got_addr[$];
  logic [DW-1:0] got_data[$];

  always @(negedge clock) begin
    if (bus.buf_wr_en === 1'b1) begin
      got_addr.push_back(bus.buf_wr_addr);
      got_data.push_back(bus.buf_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_s_ready"},   32'(bus.s_ready),     32'd0);
    chk({tag, "_wr_en"},     32'(bus.buf_wr_en),   32'd0);
    chk({tag, "_wr_addr"},   32'(bus.buf_wr_addr), 32'd0);
    chk({tag, "_wr_data"},   32'(bus.buf_wr_data), 32'd0);
    chk({tag, "_half_full"}, 32'(half_full),       32'd0);
    chk({tag, "_load_done"}, 32'(load_done),       32'd0);
    chk({tag, "_load_half"}, 32'(load_half),       32'd0);
    chk({tag, "_busy"},      32'(busy),            32'd0);
    chk({tag, "_err_cfg"},   32'(err_cfg),         32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [7:0] base, input int n);
    chk({tag, "_wr_count"}, 32'(got_addr.size()), 32'(n));
    chk({tag, "_model_count"}, 32'(exp_words.size()), 32'(n));
    for (int i = 0; i < got_addr.size() && i < n && i < exp_words.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(base + 8'(i)));
      chk($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_words[i]));
    end
    got_addr.delete();
    got_data.delete();
    exp_words.delete();
  endtask

  // Drives one request; mode 0 holds s_valid high, mode 1 toggles it.
  task automatic run_load(input int chn, input int ks, input int mode,
                          input int rel_c, input logic [1:0] rel_v,
                          output int lat, output int first_rdy,
                          output bit done_s, output bit err_s);
    bit stop;
    lat = 0; first_rdy = 0; done_s = 0; err_s = 0; stop = 0;
    @(negedge clock);
    load_start  = 1'b1;
    chn_num     = 7'(chn);
    kernel_size = 4'(ks);
    for (int c = 1; c <= 400 && !stop; c++) begin
      @(negedge clock);
      load_start = 1'b0;
      if (c == 1) chk("busy_in_check", 32'(busy), 32'd1);
      half_release = (c == rel_c) ? rel_v : 2'b00;
      if (c == rel_c) m_full = m_full & ~rel_v;
      if (load_done) begin
        lat = c; done_s = 1; stop = 1;
        bus.s_valid = 1'b0;
      end else if (err_cfg) begin
        lat = c; err_s = 1; stop = 1;
        bus.s_valid = 1'b0;
      end else begin
        if (bus.s_ready && first_rdy == 0) first_rdy = c;
        bus.s_valid = (mode == 0) ? 1'b1 : 1'(c % 2);
        bus.s_data  = DW'($urandom);
        if (bus.s_valid && bus.s_ready) exp_words.push_back(bus.s_data);
      end
    end
    bus.s_valid = 1'b0;
    @(negedge clock);
    half_release = 2'b00;
    chk("busy_after_load", 32'(busy), 32'd0);
  endtask

  task automatic do_case(input string tag, input int chn, input int ks, input int mode,
                         input int rel_c, input logic [1:0] rel_v, input int exp_first);
    int n, lat, first, exp_lat;
    bit done_s, err_s, legal;
    logic p0;
    logic [7:0] base;
    n     = (chn + 1) * ks * ks;
    legal = (ks == 1 || ks == 3 || ks == 5 || ks == 7 || ks == 9 || ks == 11) && (n <= 128);
    p0    = m_ptr;
    base  = p0 ? 8'h80 : 8'h00;
    exp_words.delete();
    run_load(chn, ks, mode, rel_c, rel_v, lat, first, done_s, err_s);
    if (legal) begin
      m_full[p0] = 1'b1;
      m_ptr      = ~p0;
      exp_lat    = (mode == 0) ? exp_first + n : exp_first + 2 * n - 1;
      chk({tag, "_done_seen"}, 32'(done_s), 32'd1);
      chk({tag, "_first_ready"}, 32'(first), 32'(exp_first));
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_writes(tag, base, n);
      chk({tag, "_load_half"}, 32'(load_half), 32'(p0));
    end else begin
      chk({tag, "_err_seen"}, 32'(err_s), 32'd1);
      chk({tag, "_err_latency"}, 32'(lat), 32'd1);
      check_writes(tag, base, 0);
    end
    chk({tag, "_half_full"}, 32'(half_full), 32'(m_full));
  endtask

  task automatic release_halves(input string tag, input logic [1:0] v);
    @(negedge clock);
    half_release = v;
    m_full = m_full & ~v;
    @(negedge clock);
    half_release = 2'b00;
    chk({tag, "_half_full"}, 32'(half_full), 32'(m_full));
  endtask

  initial begin
    int hcnt;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    chn_num      = '0;
    kernel_size  = '0;
    half_release = 2'b00;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    m_full       = 2'b00;
    m_ptr        = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    rst_n = 1'b1;

    do_case("basic_h0", 1, 3, 0, 0, 2'b00, 3);
    do_case("pingpong_h1", 1, 3, 0, 0, 2'b00, 3);
    do_case("stall_h0", 1, 3, 0, 10, 2'b01, 12);
    release_halves("rel_both", 2'b11);
    do_case("ks5_h1", 0, 5, 0, 0, 2'b00, 3);
    do_case("burst_h0", 127, 1, 1, 0, 2'b00, 3);
    do_case("err_ks4", 1, 4, 0, 0, 2'b00, 3);
    do_case("err_total", 1, 11, 0, 0, 2'b00, 3);
    release_halves("rel_both2", 2'b11);
    do_case("small_h1", 3, 1, 0, 0, 2'b00, 3);
    release_halves("rel_empty", 2'b01);
    do_case("collide_h0", 3, 1, 0, 7, 2'b01, 3);
    release_halves("rel_h1", 2'b10);

    // reset in the middle of a half-1 load
    @(negedge clock);
    load_start  = 1'b1;
    chn_num     = 7'd15;
    kernel_size = 4'd1;
    hcnt = 0;
    for (int c = 1; c < 40 && hcnt < 5; c++) begin
      @(negedge clock);
      load_start  = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = DW'($urandom);
      if (bus.s_ready) hcnt++;
    end
    chk("rst_mid_handshakes", 32'(hcnt), 32'd5);
    @(posedge clock);
    #2;
    chk("rst_mid_wr_en_before", 32'(bus.buf_wr_en), 32'd1);
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clock);
    rst_n  = 1'b1;
    m_full = 2'b00;
    m_ptr  = 1'b0;
    got_addr.delete();
    got_data.delete();
    exp_words.delete();
    do_case("post_reset_h0", 3, 1, 0, 0, 2'b00, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
